// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes,
// frame byte order and checksum/state-decode helpers.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CSUM_HI = 4'd6,
        ST_CSUM_LO = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERR     = 4'd9
    } state_t;

    // Every 16-bit frame field (LEN, data word, CSUM) arrives high byte first.
    localparam logic HI_BYTE_FIRST = 1'b1;

    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
        return acc + word;
    endfunction

    function automatic logic is_rx_state(input state_t s);
        logic r;
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
            ST_DATA_LO, ST_CSUM_HI, ST_CSUM_LO: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_busy_state(input state_t s);
        logic r;
        case (s)
            ST_IDLE, ST_DONE, ST_ERR: r = 1'b0;
            default:                  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus memory port B of the program loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_w_en;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_din, mem_w_en
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_din, mem_w_en
    );
endinterface

// File: rtl/prog_loader_byte_pair.sv
// 8-to-16 assembler: holds the first byte of a field and presents the full
// word, with a valid flag, in the same cycle the second byte is accepted.
module prog_loader_byte_pair
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic        byte_first,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        word_valid
);
    logic [7:0] first_r;

    // Latch the first byte of each field.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_r <= 8'd0;
        end else if (byte_valid && byte_first) begin
            first_r <= byte_in;
        end else begin
            first_r <= first_r;
        end
    end

    assign word       = HI_BYTE_FIRST ? {first_r, byte_in} : {byte_in, first_r};
    assign word_valid = byte_valid && !byte_first;

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory loader: receives a length/data/checksum byte frame,
// writes the words to port B and releases the CPU only after a clean load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);
    // Capacity may reach 2^16 words, hence one extra bit.
    localparam logic [16:0] CAP = 17'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

    state_t            state_r, state_next_s;
    logic              in_ready_r, w_en_r, busy_r, done_r, error_r, cpu_hold_r;
    logic [15:0]       len_r, count_r, sum_r, din_r;
    logic [ADDR_W-1:0] addr_r;
    logic              accept_s, first_s, pair_valid_s;
    logic [15:0]       pair_word_s, count_inc_s;

    assign accept_s    = bus.in_valid && in_ready_r;
    assign first_s     = (state_r == ST_LEN_HI) || (state_r == ST_DATA_HI) || (state_r == ST_CSUM_HI);
    assign count_inc_s = count_r + 16'd1;

    prog_loader_byte_pair u_pair (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (accept_s),
        .byte_first (first_s),
        .byte_in    (bus.in_data),
        .word       (pair_word_s),
        .word_valid (pair_valid_s)
    );

    // Next-state decode; start is only honoured outside an active load.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next_s = ST_LEN_HI;
                else       state_next_s = state_r;
            end
            ST_LEN_HI: begin
                if (accept_s) state_next_s = ST_LEN_LO;
                else          state_next_s = state_r;
            end
            ST_LEN_LO: begin
                if (!pair_valid_s)                   state_next_s = state_r;
                else if ({1'b0, pair_word_s} > CAP)  state_next_s = ST_ERR;
                else if (pair_word_s == 16'd0)       state_next_s = ST_CSUM_HI;
                else                                 state_next_s = ST_DATA_HI;
            end
            ST_DATA_HI: begin
                if (accept_s) state_next_s = ST_DATA_LO;
                else          state_next_s = state_r;
            end
            ST_DATA_LO: begin
                if (pair_valid_s) state_next_s = ST_WRITE;
                else              state_next_s = state_r;
            end
            ST_WRITE: begin
                if (count_inc_s == len_r) state_next_s = ST_CSUM_HI;
                else                      state_next_s = ST_DATA_HI;
            end
            ST_CSUM_HI: begin
                if (accept_s) state_next_s = ST_CSUM_LO;
                else          state_next_s = state_r;
            end
            ST_CSUM_LO: begin
                if (!pair_valid_s)             state_next_s = state_r;
                else if (pair_word_s == sum_r) state_next_s = ST_DONE;
                else                           state_next_s = ST_ERR;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; outputs are registered from the next state so they
    // decode exactly the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            w_en_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            cpu_hold_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= is_rx_state(state_next_s);
            w_en_r     <= (state_next_s == ST_WRITE);
            busy_r     <= is_busy_state(state_next_s);
            done_r     <= (state_next_s == ST_DONE);
            error_r    <= (state_next_s == ST_ERR);
            cpu_hold_r <= (state_next_s != ST_DONE);
        end
    end

    // Length, word, checksum and address datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r   <= 16'd0;
            count_r <= 16'd0;
            sum_r   <= 16'd0;
            din_r   <= 16'd0;
            addr_r  <= ADDR_W'(BASE_ADDR);
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        len_r   <= 16'd0;
                        count_r <= 16'd0;
                        sum_r   <= 16'd0;
                        addr_r  <= ADDR_W'(BASE_ADDR);
                    end
                end
                ST_LEN_LO: begin
                    if (pair_valid_s) len_r <= pair_word_s;
                end
                ST_DATA_LO: begin
                    if (pair_valid_s) din_r <= pair_word_s;
                end
                ST_WRITE: begin
                    sum_r   <= csum_add(sum_r, din_r);
                    count_r <= count_inc_s;
                    // Hold the address after the final word so it never wraps.
                    if (count_inc_s != len_r) addr_r <= addr_r + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.mem_w_en = w_en_r;
    assign bus.mem_addr = addr_r;
    assign bus.mem_din  = din_r;
    assign cpu_hold     = cpu_hold_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame vectors from a table plus hand-written
// sequences for full capacity, handshake stalls and reset mid-load.
module tb_prog_loader;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic reset, start;
    logic cpu_hold, busy, done, error;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ready_in_write = 0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [15:0]       wr_data_q[$];

    always @(posedge clk) begin
        if (!reset && bus.mem_w_en) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_din);
            if (bus.in_ready) ready_in_write++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] frame;
        int          nbytes;
        int          nwr;
        logic [31:0] words;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int idle = 0;
        int wait_cnt = 0;
        while (stall && idle < 10 && $urandom_range(0, 99) < 70) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            idle++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (bus.in_ready) begin
            @(negedge clk);
        end else begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1 byte=%0h", b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] frame, input int n, input bit stall, input bit mid_start);
        for (int k = 0; k < n; k++) begin
            send_byte(frame[63-8*k -: 8], stall);
            if (mid_start && k == 3) begin
                pulse_start();
                check("mid_start_busy", 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic exp_err);
        check({tag, "_done"},     32'(done),         32'(exp_done));
        check({tag, "_error"},    32'(error),        32'(exp_err));
        check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'(!exp_done));
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int nwr, input logic [31:0] words);
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(nwr));
        for (int j = 0; j < nwr; j++) begin
            if (j < wr_addr_q.size()) begin
                check($sformatf("%s_addr%0d", tag, j), 32'(wr_addr_q[j]), 32'(j));
                check($sformatf("%s_data%0d", tag, j), 32'(wr_data_q[j]), 32'(words[31-16*j -: 16]));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_w_en"},     32'(bus.mem_w_en), 32'd0);
        check({tag, "_addr"},     32'(bus.mem_addr), 32'd0);
        check({tag, "_din"},      32'(bus.mem_din),  32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd1);
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_done"},     32'(done),         32'd0);
        check({tag, "_error"},    32'(error),        32'd0);
    endtask

    initial begin
        logic [15:0] sum;
        logic [15:0] w;
        logic [7:0]  kb;
        int          bad;

        vecs[0] = '{64'h0002_1234_ABCD_BE01, 8, 2, 32'h1234_ABCD, 1'b1, 1'b0};
        vecs[1] = '{64'h0002_1234_ABCD_BE02, 8, 2, 32'h1234_ABCD, 1'b0, 1'b1};
        vecs[2] = '{64'h0000_0000_0000_0000, 4, 0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{64'h0000_0001_0000_0000, 4, 0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[4] = '{64'h0101_0000_0000_0000, 2, 0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[5] = '{64'h0001_FFFF_FFFF_0000, 6, 1, 32'hFFFF_0000, 1'b1, 1'b0};
        vecs[6] = '{64'h0002_FFFF_0002_0001, 8, 2, 32'hFFFF_0002, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst");

        for (int i = 0; i < 7; i++) begin
            wr_addr_q.delete();
            wr_data_q.delete();
            pulse_start();
            send_frame(vecs[i].frame, vecs[i].nbytes, 1'b0, 1'b0);
            check_end($sformatf("v%0d", i), vecs[i].exp_done, vecs[i].exp_err);
            check_writes($sformatf("v%0d", i), vecs[i].nwr, vecs[i].words);
        end

        // Full capacity: 256 words at addresses 0..255.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        sum = 16'd0;
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            w = {kb, ~kb};
            sum = sum + w;
            send_byte(w[15:8], 1'b0);
            send_byte(w[7:0], 1'b0);
        end
        send_byte(sum[15:8], 1'b0);
        send_byte(sum[7:0], 1'b0);
        check_end("full", 1'b1, 1'b0);
        check("full_nwrites", 32'(wr_addr_q.size()), 32'd256);
        bad = 0;
        for (int k = 0; k < 256 && k < wr_addr_q.size(); k++) begin
            kb = 8'(k);
            w = {kb, ~kb};
            if (wr_addr_q[k] !== 8'(k) || wr_data_q[k] !== w) bad++;
        end
        check("full_contents_bad", 32'(bad), 32'd0);

        // Random in_valid gaps with a start pulse in the middle of the load.
        wr_addr_q.delete();
        wr_data_q.delete();
        ready_in_write = 0;
        pulse_start();
        send_frame(64'h0002_1234_ABCD_BE01, 8, 1'b1, 1'b1);
        check_end("stall", 1'b1, 1'b0);
        check_writes("stall", 2, 32'h1234_ABCD);
        check("stall_ready_in_write", 32'(ready_in_write), 32'd0);

        // Reset while in DATA_LO of word 1, then a clean reload.
        pulse_start();
        send_frame(64'h0002_1234_AB00_0000, 5, 1'b0, 1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        reset = 1'b0;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_frame(64'h0002_1234_ABCD_BE01, 8, 1'b0, 1'b0);
        check_end("reload", 1'b1, 1'b0);
        check_writes("reload", 2, 32'h1234_ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
